// File: rtl/gold_pkg.sv
// ---------------------------------------------------------------------------
// gold_pkg
// Shared definitions for the level-object spawner: object type encoding,
// screen geometry and the spawner state machine encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package gold_pkg;

  localparam int SCREEN_W  = 640;
  localparam int SCREEN_H  = 480;

  // Storage depth of the slot table; NUM_OBJ selects how many are used.
  localparam int MAX_SLOTS = 16;

  typedef enum logic [1:0] {
    OBJ_SMALL_GOLD = 2'b00,
    OBJ_BIG_GOLD   = 2'b01,
    OBJ_ROCK       = 2'b10,
    OBJ_DIAMOND    = 2'b11
  } obj_type_t;

  typedef enum logic [3:0] {
    IDLE,
    REQ_X,
    WAIT_X,
    GET_X,
    REQ_Y,
    WAIT_Y,
    GET_Y,
    CHECK,
    COMMIT,
    FINISH
  } spawn_state_t;

endpackage

// File: rtl/gold_spawner.sv
// ---------------------------------------------------------------------------
// gold_spawner
// Builds a level layout: for each object slot it fetches random x/y/type
// candidates from an external random generator, rejects positions outside
// the placement window, checks the candidate against every earlier placed
// slot (one slot per cycle) and commits it when it is at least MIN_DIST away
// on some axis. After MAX_TRIES collisions a slot is left empty.
//
// Ports
//   clk          system clock
//   resetN       asynchronous active-low reset
//   start        begins a new layout (accepted only when idle)
//   randomLatch  16-bit value latched by the upstream random generator
//   storeValue   one-cycle request for the generator to latch a new value
//   busy         layout in progress
//   done         one-cycle pulse when the layout is complete
//   rd_index     slot select for readout
//   rd_valid     selected slot holds an object
//   rd_x/rd_y    position of the selected slot
//   rd_type      object type of the selected slot
// ---------------------------------------------------------------------------
module gold_spawner
  import gold_pkg::*;
#(
  parameter int NUM_OBJ   = 8,
  parameter int X_MIN     = 16,
  parameter int X_MAX     = 607,
  parameter int Y_MIN     = 160,
  parameter int Y_MAX     = 447,
  parameter int MIN_DIST  = 32,
  parameter int MAX_TRIES = 16
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        start,
  input  logic [15:0] randomLatch,
  output logic        storeValue,
  output logic        busy,
  output logic        done,
  input  logic [3:0]  rd_index,
  output logic        rd_valid,
  output logic [9:0]  rd_x,
  output logic [8:0]  rd_y,
  output logic [1:0]  rd_type
);

  localparam int               TRY_W     = $clog2(MAX_TRIES + 1);
  localparam logic [TRY_W-1:0] TRY_LIMIT = TRY_W'(MAX_TRIES);
  localparam logic [3:0]       LAST_SLOT = 4'(NUM_OBJ - 1);

  spawn_state_t     state;
  logic [3:0]       slot;
  logic [3:0]       chk_idx;
  logic [TRY_W-1:0] tries;
  logic [9:0]       cand_x;
  logic [8:0]       cand_y;
  obj_type_t        cand_type;

  logic [MAX_SLOTS-1:0] obj_vld;
  logic [9:0]           obj_x    [MAX_SLOTS];
  logic [8:0]           obj_y    [MAX_SLOTS];
  obj_type_t            obj_type [MAX_SLOTS];

  logic [10:0]      sum_x;
  logic [9:0]       sum_y;
  logic             x_ok;
  logic             y_ok;
  logic [9:0]       dx;
  logic [8:0]       dy;
  logic             collide;
  logic [TRY_W-1:0] tries_inc;
  logic             unused_rand;

  // Offsets are widened by one bit so an out-of-window sum is visible.
  assign sum_x = 11'(X_MIN) + {1'b0, randomLatch[9:0]};
  assign sum_y = 10'(Y_MIN) + {1'b0, randomLatch[8:0]};
  assign x_ok  = (sum_x <= 11'(X_MAX));
  assign y_ok  = (sum_y <= 10'(Y_MAX));

  // Overlap test against the slot currently addressed by chk_idx; empty
  // (given-up) slots never block a candidate.
  assign dx = (cand_x >= obj_x[chk_idx]) ? (cand_x - obj_x[chk_idx])
                                         : (obj_x[chk_idx] - cand_x);
  assign dy = (cand_y >= obj_y[chk_idx]) ? (cand_y - obj_y[chk_idx])
                                         : (obj_y[chk_idx] - cand_y);
  assign collide = obj_vld[chk_idx] && (dx < 10'(MIN_DIST)) && (dy < 9'(MIN_DIST));

  assign tries_inc   = tries + TRY_W'(1);
  assign unused_rand = ^randomLatch[13:10];

  // Outputs are registered: each transition sets the value the output must
  // carry while in the destination state (defaults cover the common case).
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= IDLE;
      storeValue <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      slot       <= '0;
      chk_idx    <= '0;
      tries      <= '0;
      cand_x     <= '0;
      cand_y     <= '0;
      cand_type  <= OBJ_SMALL_GOLD;
      obj_vld    <= '0;
      for (int i = 0; i < MAX_SLOTS; i++) begin
        obj_x[i]    <= '0;
        obj_y[i]    <= '0;
        obj_type[i] <= OBJ_SMALL_GOLD;
      end
    end else begin
      storeValue <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b1;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (start) begin
            obj_vld    <= '0;
            slot       <= '0;
            tries      <= '0;
            state      <= REQ_X;
            storeValue <= 1'b1;
            busy       <= 1'b1;
          end
        end
        REQ_X:  state <= WAIT_X;
        WAIT_X: state <= GET_X;
        GET_X: begin
          // Out-of-window draws are simply redrawn; they do not cost a try.
          storeValue <= 1'b1;
          if (x_ok) begin
            cand_x <= sum_x[9:0];
            state  <= REQ_Y;
          end else begin
            state  <= REQ_X;
          end
        end
        REQ_Y:  state <= WAIT_Y;
        WAIT_Y: state <= GET_Y;
        GET_Y: begin
          if (y_ok) begin
            cand_y    <= sum_y[8:0];
            cand_type <= obj_type_t'(randomLatch[15:14]);
            chk_idx   <= '0;
            state     <= CHECK;
          end else begin
            storeValue <= 1'b1;
            state      <= REQ_Y;
          end
        end
        CHECK: begin
          if (slot == 4'd0) begin
            state <= COMMIT;
          end else if (collide) begin
            if (tries_inc == TRY_LIMIT) begin
              // Give up on this slot: leave it empty and move on.
              tries <= '0;
              if (slot == LAST_SLOT) begin
                state <= FINISH;
                done  <= 1'b1;
              end else begin
                slot       <= slot + 4'd1;
                state      <= REQ_X;
                storeValue <= 1'b1;
              end
            end else begin
              tries      <= tries_inc;
              state      <= REQ_X;
              storeValue <= 1'b1;
            end
          end else if (chk_idx == slot - 4'd1) begin
            state <= COMMIT;
          end else begin
            chk_idx <= chk_idx + 4'd1;
          end
        end
        COMMIT: begin
          obj_x[slot]    <= cand_x;
          obj_y[slot]    <= cand_y;
          obj_type[slot] <= cand_type;
          obj_vld[slot]  <= 1'b1;
          tries          <= '0;
          if (slot == LAST_SLOT) begin
            state <= FINISH;
            done  <= 1'b1;
          end else begin
            slot       <= slot + 4'd1;
            state      <= REQ_X;
            storeValue <= 1'b1;
          end
        end
        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Slots at or beyond NUM_OBJ read back as empty and zero.
  always_comb begin
    rd_valid = 1'b0;
    rd_x     = '0;
    rd_y     = '0;
    rd_type  = '0;
    if ({28'd0, rd_index} < 32'(NUM_OBJ)) begin
      rd_valid = obj_vld[rd_index];
      rd_x     = obj_x[rd_index];
      rd_y     = obj_y[rd_index];
      rd_type  = obj_type[rd_index];
    end
  end

endmodule

// File: tb/tb_gold_spawner.sv
// ---------------------------------------------------------------------------
// tb_gold_spawner
// Scoreboard bench for gold_spawner (NUM_OBJ=2, MAX_TRIES=2). Expected slot
// contents are queued when a layout is launched and popped against the
// readout port once done pulses. A scripted random generator updates
// randomLatch one cycle after each storeValue request.
// ---------------------------------------------------------------------------
module tb_gold_spawner;
  import gold_pkg::*;

  localparam int N_OBJ = 2;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        start = 1'b0;
  logic [15:0] randomLatch = 16'h0000;
  logic        storeValue;
  logic        busy;
  logic        done;
  logic [3:0]  rd_index = 4'd0;
  logic        rd_valid;
  logic [9:0]  rd_x;
  logic [8:0]  rd_y;
  logic [1:0]  rd_type;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic v;
    int   x;
    int   y;
    int   t;
  } exp_t;

  logic [15:0] script_q[$];
  exp_t        exp_q[$];

  gold_spawner #(.NUM_OBJ(N_OBJ), .MAX_TRIES(2)) dut (
    .clk         (clk),
    .resetN      (resetN),
    .start       (start),
    .randomLatch (randomLatch),
    .storeValue  (storeValue),
    .busy        (busy),
    .done        (done),
    .rd_index    (rd_index),
    .rd_valid    (rd_valid),
    .rd_x        (rd_x),
    .rd_y        (rd_y),
    .rd_type     (rd_type)
  );

  always #5 clk = ~clk;

  // Scripted generator: a request seen this cycle is answered after the edge.
  initial begin
    forever begin
      @(negedge clk);
      if (storeValue === 1'b1) begin
        @(posedge clk);
        #1;
        if (script_q.size() > 0) randomLatch = script_q.pop_front();
        else                     randomLatch = 16'h0000;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic v, input int x, input int y, input int t);
    exp_t e;
    e.v = v; e.x = x; e.y = y; e.t = t;
    exp_q.push_back(e);
  endtask

  // Launch a layout, count cycles and generator requests until done, then
  // drain the scoreboard against the readout port.
  task automatic run_layout(input string name, input int exp_lat, input int exp_sv,
                            input int inject_at);
    int   cnt  = 0;
    int   sv   = 0;
    bit   seen = 1'b0;
    exp_t e;
    start = 1'b1;
    while (!seen && cnt < 300) begin
      @(posedge clk);
      #1;
      cnt++;
      start = (cnt == inject_at);
      if (storeValue === 1'b1) sv++;
      if (done === 1'b1) seen = 1'b1;
    end
    start = 1'b0;
    chk({name, "_done_seen"}, 32'(seen), 1);
    chk({name, "_latency"}, cnt, exp_lat);
    chk({name, "_stores"}, sv, exp_sv);
    chk({name, "_busy_at_done"}, 32'(busy), 1);
    chk({name, "_script_used"}, script_q.size(), 0);
    @(posedge clk);
    #1;
    chk({name, "_done_pulse_end"}, 32'(done), 0);
    chk({name, "_busy_idle"}, 32'(busy), 0);
    for (int i = 0; i < N_OBJ; i++) begin
      if (exp_q.size() == 0) begin
        chk({name, "_sb_empty"}, 0, 1);
      end else begin
        e = exp_q.pop_front();
        rd_index = 4'(i);
        #1;
        chk($sformatf("%s_valid%0d", name, i), 32'(rd_valid), 32'(e.v));
        if (e.v) begin
          chk($sformatf("%s_x%0d", name, i), 32'(rd_x), e.x);
          chk($sformatf("%s_y%0d", name, i), 32'(rd_y), e.y);
          chk($sformatf("%s_type%0d", name, i), 32'(rd_type), e.t);
        end
      end
    end
  endtask

  initial begin
    int done_seen;
    int busy_seen;

    // Reset state
    resetN = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_store", 32'(storeValue), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    for (int i = 0; i < N_OBJ; i++) begin
      rd_index = 4'(i);
      #1;
      chk($sformatf("rst_valid%0d", i), 32'(rd_valid), 0);
      chk($sformatf("rst_x%0d", i), 32'(rd_x), 0);
      chk($sformatf("rst_y%0d", i), 32'(rd_y), 0);
      chk($sformatf("rst_type%0d", i), 32'(rd_type), 0);
    end
    resetN = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_busy", 32'(busy), 0);

    // Collision on slot 1, retry commits; a start while busy is ignored.
    script_q = '{16'h0064, 16'h4032, 16'h0072, 16'h003C, 16'h00B8, 16'h803C};
    push_exp(1'b1, 116, 210, 1);
    push_exp(1'b1, 200, 220, 2);
    run_layout("collide_retry", 24, 6, 5);

    // Out-of-window x and y draws are redrawn.
    script_q = '{16'h03FF, 16'h0064, 16'h4032, 16'h0190, 16'h01FF, 16'h0000};
    push_exp(1'b1, 116, 210, 1);
    push_exp(1'b1, 416, 160, 0);
    run_layout("reject", 23, 6, 0);

    // Repeated collisions exhaust MAX_TRIES: slot 1 stays empty.
    script_q = '{16'h0064, 16'h4032, 16'h0072, 16'h003C, 16'h0072, 16'h003C};
    push_exp(1'b1, 116, 210, 1);
    push_exp(1'b0, 0, 0, 0);
    run_layout("give_up", 23, 6, 0);

    // Window edges: X_MAX/Y_MAX accepted, X_MAX+1 rejected.
    script_q = '{16'h024F, 16'hC11F, 16'h0250, 16'h0000, 16'h0000};
    push_exp(1'b1, 607, 447, 3);
    push_exp(1'b1, 16, 160, 0);
    run_layout("edges", 20, 5, 0);

    // Exactly MIN_DIST apart on x is not a collision.
    script_q = '{16'h0064, 16'h4032, 16'h0084, 16'h0032};
    push_exp(1'b1, 116, 210, 1);
    push_exp(1'b1, 148, 210, 0);
    run_layout("dist_edge", 17, 4, 0);

    // Out-of-range readout
    rd_index = 4'd15;
    #1;
    chk("oor15_valid", 32'(rd_valid), 0);
    chk("oor15_x", 32'(rd_x), 0);
    chk("oor15_y", 32'(rd_y), 0);
    chk("oor15_type", 32'(rd_type), 0);
    rd_index = 4'd2;
    #1;
    chk("oor2_valid", 32'(rd_valid), 0);

    // Table persists while idle
    repeat (10) @(posedge clk);
    #1;
    rd_index = 4'd1;
    #1;
    chk("persist_valid1", 32'(rd_valid), 1);
    chk("persist_x1", 32'(rd_x), 148);

    // Reset during slot-0 CHECK aborts the layout.
    script_q = '{16'h0064, 16'h4032, 16'h0190, 16'h0000};
    start = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    chk("abort_busy_before", 32'(busy), 1);
    resetN = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_store", 32'(storeValue), 0);
    chk("abort_done", 32'(done), 0);
    rd_index = 4'd0;
    #1;
    chk("abort_valid0", 32'(rd_valid), 0);
    chk("abort_x0", 32'(rd_x), 0);
    rd_index = 4'd1;
    #1;
    chk("abort_valid1", 32'(rd_valid), 0);
    repeat (2) @(posedge clk);
    #1;
    resetN = 1'b1;
    done_seen = 0;
    busy_seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) done_seen++;
      if (busy === 1'b1) busy_seen++;
    end
    chk("abort_no_done", done_seen, 0);
    chk("abort_stays_idle", busy_seen, 0);
    script_q.delete();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
